fft_cbfp_idx_sched: RTL

Ping-pong index buffer and read scheduler for the CBFP stage of the FFT pipeline. Captures the per-beat block exponents (`index_h`, `index_l`) that the CBFP normalizer emits alongside each 16-lane beat, and groups them into frames. It then replays each completed frame to the downstream exponent-compensation stage under a valid/ready handshake. It sits between the CBFP normalizer output and the final renormalizer, decoupling the free-running CBFP stream from a back-pressuring consumer.

---
 rtl/fft_cbfp_idx_sched.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fft_cbfp_idx_sched.sv
// Ping-pong CBFP exponent buffer: captures {index_h, index_l} per beat into two
// frame banks and replays each full bank under valid/ready. Option: FFT_CBFP_OVF_CHK_EN.
module fft_cbfp_idx_sched #(
  parameter int BEATS = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             val_in,
  input  logic [IDX_W-1:0] index_h,
  input  logic [IDX_W-1:0] index_l,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx_h,
  output logic [IDX_W-1:0] out_idx_l,
  output logic             out_first,
  output logic             out_last,
  output logic [1:0]       bank_full,
  output logic             ovf_err
);

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [1:0]       r_full;
  logic [2*IDX_W-1:0] r_mem [2*BEATS];

  logic               w_rd_hs;
  logic               w_rd_done;
  logic               w_wr_ok;
  logic               w_wr_acc;
  logic               w_wr_done;
  logic [1:0]         w_full_nxt;
  logic [2*IDX_W-1:0] w_rd_word;

  assign w_rd_hs   = (r_state == S_DRAIN) && out_ready;
  assign w_rd_done = w_rd_hs && (r_rd_cnt == LAST);
  // A full bank may take a new beat in the very cycle its last entry is read out.
  assign w_wr_ok   = !r_full[r_wr_bank] || (w_rd_done && (r_rd_bank == r_wr_bank));
  assign w_wr_acc  = val_in && w_wr_ok;
  assign w_wr_done = w_wr_acc && (r_wr_cnt == LAST);

  // Write side: storage and frame bookkeeping
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[{r_wr_bank, r_wr_cnt}] <= {index_h, index_l};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_wr_acc) begin
      if (w_wr_done) begin
        r_wr_cnt  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else begin
        r_wr_cnt  <= r_wr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_done) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_full <= 2'b00;
    else     r_full <= w_full_nxt;
  end

  // Read side: drain FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_full[r_rd_bank]) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_rd_hs) begin
            if (r_rd_cnt == LAST) begin
              r_rd_cnt  <= '0;
              r_rd_bank <= ~r_rd_bank;
              r_state   <= S_IDLE;
            end else begin
              r_rd_cnt  <= r_rd_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_rd_word = r_mem[{r_rd_bank, r_rd_cnt}];
  assign out_valid = (r_state == S_DRAIN);
  assign out_idx_h = out_valid ? w_rd_word[2*IDX_W-1:IDX_W] : '0;
  assign out_idx_l = out_valid ? w_rd_word[IDX_W-1:0] : '0;
  assign out_first = out_valid && (r_rd_cnt == '0);
  assign out_last  = out_valid && (r_rd_cnt == LAST);
  assign bank_full = r_full;

`ifdef FFT_CBFP_OVF_CHK_EN
  logic w_drop;
  logic r_ovf;
  assign w_drop = val_in && !w_wr_ok;
  always_ff @(posedge clk) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end
  assign ovf_err = r_ovf;
`else
  assign ovf_err = 1'b0;
`endif

endmodule
